lsu_mem_if: RTL

Load/store adapter between the core's data-memory port and the 32-bit word-addressed synchronous RAM wrapper. It accepts one byte-addressed load or store at a time and checks alignment. It drives the RAM's valid/ready request channel with a word address, replicated write data and a byte write mask. For loads it waits for the RAM's read-valid, then extracts and sign- or zero-extends the addressed byte, half or word into a single-cycle response.

---
 rtl/lsu_mem_if.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_if.sv
// Load/store adapter between the core data-memory port and a 32-bit
// word-addressed synchronous RAM. One transaction in flight at a time:
// alignment check, RAM request handshake, then a single-cycle response.
module lsu_mem_if #(
  parameter int unsigned AddrWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // core request
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth+1:0]   req_addr_i,
  input  logic                   req_we_i,
  input  logic [1:0]             req_size_i,
  input  logic                   req_unsigned_i,
  input  logic [31:0]            req_wdata_i,
  // core response
  output logic                   resp_valid_o,
  output logic [31:0]            resp_rdata_o,
  output logic                   resp_err_o,
  // RAM request channel
  output logic                   mem_valid_o,
  input  logic                   mem_ready_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [31:0]            mem_wr_data_o,
  output logic [3:0]             mem_wr_en_o,
  // RAM read return
  input  logic [31:0]            mem_rd_data_i,
  input  logic                   mem_rd_valid_i
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } state_e;

  state_e               state_q, state_d;

  // latched request
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [1:0]           off_q, off_d;
  logic                 we_q, we_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [3:0]           mask_q, mask_d;
  logic [31:0]          wdata_q, wdata_d;

  // registered response
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;

  // decoded incoming request
  logic [1:0]           req_off;
  logic                 req_misaligned;
  logic [3:0]           req_mask;
  logic [31:0]          req_data;

  // load data alignment / extension
  logic [31:0]          rd_shifted;
  logic [31:0]          rd_extended;

  // Decode alignment, byte mask and replicated write data of the incoming request
  always_comb begin
    req_off        = req_addr_i[1:0];
    req_misaligned = 1'b0;
    req_mask       = '0;
    req_data       = '0;
    unique case (req_size_i)
      2'd0: begin
        req_mask = 4'b0001 << req_off;
        req_data = {4{req_wdata_i[7:0]}};
      end
      2'd1: begin
        req_misaligned = req_off[0];
        req_mask       = 4'b0011 << req_off;
        req_data       = {2{req_wdata_i[15:0]}};
      end
      2'd2: begin
        req_misaligned = (req_off != 2'd0);
        req_mask       = 4'b1111;
        req_data       = req_wdata_i;
      end
      default: begin
        req_misaligned = 1'b1;
      end
    endcase
    // loads never write
    if (!req_we_i) begin
      req_mask = '0;
      req_data = '0;
    end
  end

  // Right-align the addressed lane of the RAM word and sign/zero-extend it
  always_comb begin
    rd_shifted  = mem_rd_data_i >> {off_q, 3'b000};
    rd_extended = rd_shifted;
    unique case (size_q)
      2'd0:    rd_extended = {{24{~uns_q & rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1:    rd_extended = {{16{~uns_q & rd_shifted[15]}}, rd_shifted[15:0]};
      default: rd_extended = rd_shifted;
    endcase
  end

  // Next-state logic: request latch, RAM handshake and response capture
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i[AddrWidth+1:2];
          off_d   = req_off;
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          mask_d  = req_mask;
          wdata_d = req_data;
          rdata_d = '0;
          err_d   = req_misaligned;
          state_d = req_misaligned ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready_i) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = we_q ? RESP : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (mem_rd_valid_i) begin
          rdata_d = rd_extended;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      mask_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from state; RAM and response fields are zero when not active
  always_comb begin
    req_ready_o   = (state_q == IDLE);
    mem_valid_o   = (state_q == ISSUE);
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    mem_wr_en_o   = '0;
    resp_valid_o  = (state_q == RESP);
    resp_rdata_o  = '0;
    resp_err_o    = 1'b0;
    if (state_q == ISSUE) begin
      mem_addr_o    = addr_q;
      mem_wr_data_o = wdata_q;
      mem_wr_en_o   = mask_q;
    end
    if (state_q == RESP) begin
      resp_rdata_o = rdata_q;
      resp_err_o   = err_q;
    end
  end

endmodule
